// File: rtl/ifetch.sv
// Purpose : instruction fetch - drives the ROM address from the PC and queues {pc, word} for decode.
// Latency : first fetched word is presented the cycle after the fetch edge; a redirect costs one bubble.
// Backpr. : instr_valid/instr_ready; fetch stalls when the queue is full and the head is not consumed.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   imem_addr        ROM byte address (always the PC register)
//   imem_data        ROM word at imem_addr, same cycle
//   instr_valid/_ready, instr, instr_pc   decoder handshake with head word and its PC
//   redirect_valid, redirect_pc           taken branch/jump: flush and refetch
//   fetch_err        misaligned-redirect trap flag
//
// Build option: define IFETCH_MISALIGN_TRAP_EN to trap misaligned redirects
// (sticky fetch_err, fetch halted); otherwise the target is silently word-aligned.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_pc;

    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push;
    logic            w_halt;
    entry_t          w_head;
    entry_t          w_tail;

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic            r_err;
    assign w_halt = r_err;
`else
    // Low target bits are dropped on purpose in this build.
    logic            w_unused;
    assign w_unused = ^redirect_pc[1:0];
    assign w_halt   = 1'b0;
`endif

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && instr_ready;
    // A pop frees the slot in the same cycle, so a full queue still streams.
    assign w_push  = !redirect_valid && !w_halt && (!w_full || w_pop);

    assign w_head      = r_mem[r_rd];
    assign w_tail      = '{pc: r_pc, word: imem_data};
    assign imem_addr   = r_pc;
    assign instr_valid = !w_empty;
    assign instr       = w_head.word;
    assign instr_pc    = w_head.pc;
    assign fetch_err   = w_halt;

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= w_tail;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            r_err   <= 1'b0;
`endif
        end else if (redirect_valid) begin
            // Flush wins over any same-cycle pop; the popped entry is simply gone.
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            r_pc    <= redirect_pc;
            r_err   <= (redirect_pc[1:0] != 2'b00);
`else
            r_pc    <= {redirect_pc[31:2], 2'b00};
`endif
        end else begin
            if (w_push) begin
                r_wr <= r_wr + AW'(1);
                r_pc <= r_pc + 32'd4;
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Purpose : self-checking bench for ifetch against a queue-based reference model.
// Latency : model is stepped once per rising edge; outputs compared at the falling edge.
// Backpr. : instr_ready driven by directed scenarios and random stimulus.
module tb_ifetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_err;

    ifetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_err      (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: rom_word = 32'h0000_0000;
            32'h0000_0004: rom_word = 32'h02A0_0093;
            32'h0000_0008: rom_word = 32'h02A0_8093;
            32'h0000_0014: rom_word = 32'h0020_8463;
            default:       rom_word = (addr * 32'd2654435761) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    always_comb imem_data = rom_word(imem_addr);

    int n_checks;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: queue of PCs waiting for decode, the fetch PC and the trap flag.
    logic [31:0] mq[$];
    logic [31:0] mpc;
    logic        merr;

    // Handshakes observed on the DUT interface (pc and word), for directed checks.
    logic [31:0] got_pc[$];
    logic [31:0] got_ins[$];

    task automatic compare_model();
        check("valid", {31'b0, instr_valid}, {31'b0, mq.size() != 0});
        check("imem_addr", imem_addr, mpc);
        check("fetch_err", {31'b0, fetch_err}, {31'b0, merr});
        if (mq.size() != 0) begin
            check("instr_pc", instr_pc, mq[0]);
            check("instr", instr, rom_word(mq[0]));
        end
    endtask

    task automatic model_edge(input logic r_in, input logic rdy, input logic rv,
                              input logic [31:0] rp);
        logic popped;
        popped = (mq.size() != 0) && rdy;
        if (r_in) begin
            mq.delete();
            mpc  = RESET_PC;
            merr = 1'b0;
        end else if (rv) begin
            mq.delete();
`ifdef IFETCH_MISALIGN_TRAP_EN
            mpc  = rp;
            merr = (rp % 4) != 0;
`else
            mpc  = rp - (rp % 4);
`endif
        end else begin
            if (popped) void'(mq.pop_front());
            if (!merr && mq.size() < DEPTH) begin
                mq.push_back(mpc);
                mpc = mpc + 32'd4;
            end
        end
    endtask

    // One clock: check the settled outputs, drive new inputs, advance the model on the edge.
    task automatic step(input logic r_in, input logic rdy, input logic rv,
                        input logic [31:0] rp);
        @(negedge clk);
        compare_model();
        rst            = r_in;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rp;
        if (!r_in && instr_valid && rdy) begin
            got_pc.push_back(instr_pc);
            got_ins.push_back(instr);
        end
        @(posedge clk);
        model_edge(r_in, rdy, rv, rp);
    endtask

    task automatic clear_got();
        got_pc.delete();
        got_ins.delete();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (2) @(posedge clk);
        mq.delete();
        mpc  = RESET_PC;
        merr = 1'b0;
        #1;
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_err", {31'b0, fetch_err}, 32'd0);

        // 1: streaming from reset, one instruction per cycle after the first fill.
        clear_got();
        repeat (7) step(1'b0, 1'b1, 1'b0, 32'h0);
        check("s1_count", got_pc.size(), 32'd6);
        for (int i = 0; i < 6 && i < got_pc.size(); i++) check("s1_pc", got_pc[i], 32'(4 * i));
        if (got_ins.size() >= 2) begin
            check("s1_ins0", got_ins[0], 32'h0000_0000);
            check("s1_ins1", got_ins[1], 32'h02A0_0093);
        end

        // 2: stall fills the queue, then drain without gaps or repeats.
        do_reset();
        repeat (5) step(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check("s2_addr", imem_addr, 32'(4 * DEPTH));
        check("s2_head", instr_pc, 32'h0);
        check("s2_valid", {31'b0, instr_valid}, 32'd1);
        clear_got();
        repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0);
        check("s2_count", got_pc.size(), 32'd4);
        for (int i = 0; i < 4 && i < got_pc.size(); i++) check("s2_pc", got_pc[i], 32'(4 * i));

        // 3: redirect while the queue holds 8 and 12.
        do_reset();
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) step(1'b0, 1'b1, 1'b0, 32'h0);
        #1;
        check("s3_pre_head", instr_pc, 32'h8);
        clear_got();
        step(1'b0, 1'b0, 1'b1, 32'h1C);
        #1;
        check("s3_bubble", {31'b0, instr_valid}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check("s3_valid", {31'b0, instr_valid}, 32'd1);
        check("s3_target", instr_pc, 32'h1C);
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
        check("s3_first", (got_pc.size() != 0) ? got_pc[0] : 32'hDEAD_BEEF, 32'h1C);

        // 4: PC wraps past the top of the address space.
        clear_got();
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
        repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0);
        check("s4_count", got_pc.size(), 32'd3);
        if (got_pc.size() >= 3) begin
            check("s4_pc0", got_pc[0], 32'hFFFF_FFF8);
            check("s4_pc1", got_pc[1], 32'hFFFF_FFFC);
            check("s4_pc2", got_pc[2], 32'h0000_0000);
        end

        // 5: reset overrides a pending redirect on a full queue.
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'h40);
        #1;
        check("s5_valid", {31'b0, instr_valid}, 32'd0);
        check("s5_addr", imem_addr, RESET_PC);
        clear_got();
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
        check("s5_first", (got_pc.size() != 0) ? got_pc[0] : 32'hDEAD_BEEF, 32'h0);

        // 6: misaligned redirect.
        step(1'b0, 1'b0, 1'b1, 32'h6);
`ifdef IFETCH_MISALIGN_TRAP_EN
        #1;
        check("s6_err", {31'b0, fetch_err}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            #1;
            check("s6_halt", {31'b0, instr_valid}, 32'd0);
        end
        step(1'b0, 1'b1, 1'b1, 32'h8);
        #1;
        check("s6_clear", {31'b0, fetch_err}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check("s6_resume", instr_pc, 32'h8);
`else
        step(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check("s6_align", instr_pc, 32'h4);
        check("s6_noerr", {31'b0, fetch_err}, 32'd0);
`endif

        // Random phase: mixed stalls, redirects (some misaligned, some near wrap) and resets.
        for (int i = 0; i < 600; i++) begin
            logic        r_in;
            logic        rv;
            logic [31:0] rp;
            r_in = ($urandom_range(0, 59) == 0);
            rv   = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       rp = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                1:       rp = 32'($urandom_range(0, 255));
                default: rp = $urandom() & 32'hFFFF_FFFC;
            endcase
            step(r_in, 1'($urandom_range(0, 1)), rv, rp);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
